// File: rtl/sif_pkg.sv
// rtl/sif_pkg.sv - shared types and default constants for the sif link
package sif_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sif_rx_state_t;

  localparam int SIF_DATA_W      = 8;
  localparam int SIF_FIFO_DEPTH  = 4;
  localparam int SIF_SYNC_STAGES = 2;

endpackage

// File: rtl/sif_rx_if.sv
// rtl/sif_rx_if.sv - serial link inputs and word read port of sif_rx
interface sif_rx_if
  import sif_pkg::*;
#(
  parameter int DATA_W     = SIF_DATA_W,
  parameter int FIFO_DEPTH = SIF_FIFO_DEPTH
);

  logic                          sck;
  logic                          sdat;
  logic                          sen;
  logic [DATA_W-1:0]             rd_data;
  logic                          rd_valid;
  logic                          rd_ready;
  logic                          frame_err;
  logic                          ovf;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output sck, sdat, sen, rd_ready,
    input  rd_data, rd_valid, frame_err, ovf, fifo_level
  );

  modport slave (
    input  sck, sdat, sen, rd_ready,
    output rd_data, rd_valid, frame_err, ovf, fifo_level
  );

endinterface

// File: rtl/sif_rx_fifo.sv
// rtl/sif_rx_fifo.sv - synchronous FIFO with registered head word
module sif_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [DATA_W-1:0]      head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_ok, pop_ok;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = head_q;

  always_comb begin
    pop_ok   = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    push_ok  = push & (~full | pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    head_d = (level_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/sif_rx.sv
// rtl/sif_rx.sv - three-wire serial receiver with output word FIFO
module sif_rx
  import sif_pkg::*;
#(
  parameter int DATA_W         = SIF_DATA_W,
  parameter int FIFO_DEPTH     = SIF_FIFO_DEPTH,
  parameter int SYNC_STAGES    = SIF_SYNC_STAGES,
  parameter bit SEN_ACTIVE_LOW = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  sif_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TOP   = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
  logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
  logic [SYNC_STAGES-1:0] sync_fill_q, sync_fill_d;
  logic                   sck_hist_q, sck_hist_d;
  logic                   sen_hist_q, sen_hist_d;
  logic                   armed_q, armed_d;

  sif_rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]      shreg_q, shreg_d;
  logic                   push_q, push_d;
  logic [DATA_W-1:0]      push_data_q, push_data_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sck_rise, frm_start, frm_end, start_ok;
  logic                   sen_act, sen_act_hist, sdat_s;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [LVL_W-1:0]       fifo_level;
  logic [DATA_W-1:0]      fifo_head;

  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
    sdat_sync_d  = {sdat_sync_q[SYNC_STAGES-2:0], bus.sdat};
    sen_sync_d   = {sen_sync_q[SYNC_STAGES-2:0], bus.sen};
    sync_fill_d  = {sync_fill_q[SYNC_STAGES-2:0], 1'b1};
    sck_hist_d   = sck_sync_q[TOP];
    sen_hist_d   = sen_sync_q[TOP];
    sdat_s       = sdat_sync_q[TOP];
    sen_act      = sen_sync_q[TOP] ^ SEN_ACTIVE_LOW;
    sen_act_hist = sen_hist_q ^ SEN_ACTIVE_LOW;
    sck_rise     = sck_sync_q[TOP] & ~sck_hist_q;
    frm_start    = sen_act & ~sen_act_hist;
    frm_end      = ~sen_act & sen_act_hist;
    // Arm only on an inactive sen that came from the pin, not from reset values,
    // so a frame still running across reset is not mistaken for a new start.
    armed_d      = armed_q | (sync_fill_q[TOP] & ~sen_act);
    start_ok     = frm_start & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      sdat_sync_q <= '0;
      sen_sync_q  <= {SYNC_STAGES{SEN_ACTIVE_LOW}};
      sync_fill_q <= '0;
      sck_hist_q  <= 1'b0;
      sen_hist_q  <= SEN_ACTIVE_LOW;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      sdat_sync_q <= sdat_sync_d;
      sen_sync_q  <= sen_sync_d;
      sync_fill_q <= sync_fill_d;
      sck_hist_q  <= sck_hist_d;
      sen_hist_q  <= sen_hist_d;
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SHIFT;
      SHIFT:   if (frm_end)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shreg_d = {shreg_q[DATA_W-3:0], sdat_s};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            push_d      = 1'b1;
            push_data_d = {shreg_q, sdat_s};
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        // The edge above is already folded in, so a word completing on the
        // closing cycle is pushed rather than flagged.
        if (frm_end) begin
          frame_err_d = (bit_cnt_d != '0);
          bit_cnt_d   = '0;
          shreg_d     = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign fifo_pop = bus.rd_ready & ~fifo_empty;

  sif_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head_data (fifo_head)
  );

  assign bus.rd_data    = fifo_head;
  assign bus.rd_valid   = ~fifo_empty;
  assign bus.fifo_level = fifo_level;
  assign bus.frame_err  = frame_err_q;
  assign bus.ovf        = push_q & fifo_full & ~fifo_pop;

endmodule
